// File: rtl/fc_ifmap_feeder.sv
// fc_ifmap_feeder: streams one activation vector into the FC PE chain; FC_FEEDER_DRAIN_EN adds a FC_SIZE-cycle drain.
module fc_ifmap_feeder #(
  parameter int FC_SIZE = 128,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             src_valid_i,
  input  logic [7:0]       src_data_i,
  output logic             src_ready_o,
  output logic [7:0]       ifmap_o,
  output logic             pe_load_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             underflow_o
);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] len_q, cnt;
  logic acc;
  assign acc = src_ready_o & src_valid_i;
`ifdef FC_FEEDER_DRAIN_EN
  logic [CNT_W-1:0] dcnt;
  logic drain_end;
  assign drain_end = dcnt == CNT_W'(FC_SIZE - 1);
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_i ? LOAD : IDLE;
      LOAD:    state_n = STREAM;
`ifdef FC_FEEDER_DRAIN_EN
      STREAM:  state_n = (acc && cnt == len_q) ? DRAIN : STREAM;
      DRAIN:   state_n = drain_end ? DONE : DRAIN;
`else
      STREAM:  state_n = (acc && cnt == len_q) ? DONE : STREAM;
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      cnt         <= '0;
      src_ready_o <= 1'b0;
      ifmap_o     <= '0;
      pe_load_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state       <= state_n;
      src_ready_o <= state_n == STREAM;
      pe_load_o   <= state_n == LOAD;
      busy_o      <= state_n == LOAD || state_n == STREAM || state_n == DRAIN;
      done_o      <= state_n == DONE;
      ifmap_o     <= acc ? src_data_i : 8'h00;
      if (state == IDLE && start_i) begin
        len_q       <= len_i;
        cnt         <= '0;
        underflow_o <= 1'b0;
      end else begin
        if (acc) cnt <= cnt + 1'b1;
        if (src_ready_o && !src_valid_i) underflow_o <= 1'b1;
      end
    end
  end
`ifdef FC_FEEDER_DRAIN_EN
  always_ff @(posedge clk) begin
    if (rst) dcnt <= '0;
    else dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
  end
`endif
endmodule

// File: tb/tb_fc_ifmap_feeder.sv
// tb_fc_ifmap_feeder: directed cycle-accurate checks of fc_ifmap_feeder, drain on or off via FC_FEEDER_DRAIN_EN.
module tb_fc_ifmap_feeder;
  localparam int FC = 4;
  localparam int DR =
`ifdef FC_FEEDER_DRAIN_EN
    FC;
`else
    0;
`endif
  logic clk = 1'b0;
  logic rst, start_i, src_valid_i, src_ready_o, pe_load_o, busy_o, done_o, underflow_o;
  logic [7:0] len_i, src_data_i, ifmap_o;
  int tests = 0, fails = 0;
  bit und_prev = 0;
  always #5 clk = ~clk;
  fc_ifmap_feeder #(.FC_SIZE(FC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
    .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
    .ifmap_o(ifmap_o), .pe_load_o(pe_load_o), .busy_o(busy_o), .done_o(done_o),
    .underflow_o(underflow_o)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input int c);
    chk({tag, "_ifmap"}, c, ifmap_o, 8'h00);
    chk({tag, "_ready"}, c, 8'(src_ready_o), 8'h00);
    chk({tag, "_load"}, c, 8'(pe_load_o), 8'h00);
    chk({tag, "_busy"}, c, 8'(busy_o), 8'h00);
    chk({tag, "_done"}, c, 8'(done_o), 8'h00);
    chk({tag, "_underflow"}, c, 8'(underflow_o), 8'h00);
  endtask
  // One pass: cycle 0 carries start_i; expectations come from the documented cycle timing.
  task automatic pass(input int len, input logic [7:0] base, input int stall, input int restart, input int rst_at);
    int n, last, done_c, acc;
    bit prev, und;
    logic [7:0] last_d;
    n = len + 1;
    last = 1 + n + ((stall >= 2 && stall <= 1 + n) ? 1 : 0);
    done_c = last + 1 + DR;
    und = stall >= 2 && stall <= last;
    acc = 0;
    prev = 0;
    last_d = 8'h00;
    for (int c = 0; c <= done_c + 1; c++) begin
      step();
      if (rst_at >= 0 && c == rst_at + 1) begin
        rst = 1'b0;
        chk_idle("after_rst", c);
        und_prev = 0;
        for (int k = 1; k <= 3; k++) begin
          step();
          chk("rst_nodone", c + k, 8'(done_o), 8'h00);
          chk("rst_notbusy", c + k, 8'(busy_o), 8'h00);
        end
        return;
      end
      chk("ifmap", c, ifmap_o, prev ? last_d : 8'h00);
      chk("pe_load", c, 8'(pe_load_o), 8'(c == 1));
      chk("ready", c, 8'(src_ready_o), 8'(c >= 2 && c <= last));
      chk("busy", c, 8'(busy_o), 8'(c >= 1 && c < done_c));
      chk("done", c, 8'(done_o), 8'(c == done_c));
      chk("underflow", c, 8'(underflow_o), 8'(c == 0 ? und_prev : (und && c > stall)));
      start_i = c == 0 || c == restart;
      len_i = c == 0 ? 8'(len) : 8'h00;
      src_valid_i = c != stall;
      src_data_i = base + 8'(acc * 17);
      rst = c == rst_at;
      prev = c >= 2 && c <= last && c != stall;
      if (prev) begin
        last_d = src_data_i;
        acc++;
      end
    end
    und_prev = und;
    start_i = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    len_i = 8'h00;
    src_valid_i = 1'b0;
    src_data_i = 8'h00;
    step();
    step();
    chk_idle("reset", 0);
    rst = 1'b0;
    pass(3, 8'h11, -1, -1, -1);
    pass(3, 8'h11, 3, -1, -1);
    pass(3, 8'h11, -1, -1, -1);
    pass(3, 8'h11, -1, 3, -1);
    pass(0, 8'h7F, -1, -1, -1);
    pass(3, 8'h11, -1, -1, DR > 0 ? 7 : 5);
    pass(3, 8'h21, 5, -1, -1);
    pass(255, 8'h11, -1, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
